// File: rtl/dsp_rr_scheduler.sv
// Round-robin front end for a shared 4-stage DSP pre-add/mul/post-add slice.
// Registers the winner's operands and returns each P result to its requester.
module dsp_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DSP_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [18*N_REQ-1:0] req_a,
  input  logic [18*N_REQ-1:0] req_b,
  input  logic [18*N_REQ-1:0] req_d,
  input  logic [48*N_REQ-1:0] req_c,
  output logic [17:0]        dsp_a,
  output logic [17:0]        dsp_b,
  output logic [17:0]        dsp_d,
  output logic [47:0]        dsp_c,
  input  logic [47:0]        dsp_p,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [47:0]        rsp_p,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] id;
  } tag_t;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [17:0]      a_q, a_d;
  logic [17:0]      b_q, b_d;
  logic [17:0]      d_q, d_d;
  logic [47:0]      c_q, c_d;
  tag_t             tag_q [DSP_LAT];
  tag_t             tag_d [DSP_LAT];
  logic [N_REQ-1:0] rsp_q, rsp_d;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_id;
  logic             found;
  logic             hs;
  int               idx;

  // Rotating first-valid search starting at the priority pointer
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = PW'(idx);
      end
    end
    hs = found & en & ~rst;
    if (hs) gnt[gnt_id] = 1'b1;
  end

  assign req_ready = gnt;

  always_comb begin
    ptr_d = ptr_q;
    a_d   = '0;
    b_d   = '0;
    d_d   = '0;
    c_d   = '0;
    if (hs) begin
      ptr_d = (gnt_id == PW'(N_REQ - 1)) ? '0 : gnt_id + PW'(1);
      a_d   = req_a[18*int'(gnt_id) +: 18];
      b_d   = req_b[18*int'(gnt_id) +: 18];
      d_d   = req_d[18*int'(gnt_id) +: 18];
      c_d   = req_c[48*int'(gnt_id) +: 48];
    end
  end

  // Tag shadow of the DSP pipe; output flop lines up with P
  always_comb begin
    tag_d[0].vld = hs;
    tag_d[0].id  = gnt_id;
    for (int k = 1; k < DSP_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rsp_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_d[i] = tag_q[DSP_LAT-1].vld &&
                 (tag_q[DSP_LAT-1].id == PW'(i));
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DSP_LAT; k++) begin
      busy = busy | tag_q[k].vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      c_q   <= '0;
      rsp_q <= '0;
      for (int k = 0; k < DSP_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      a_q   <= a_d;
      b_q   <= b_d;
      d_q   <= d_d;
      c_q   <= c_d;
      rsp_q <= rsp_d;
      for (int k = 0; k < DSP_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign dsp_a     = a_q;
  assign dsp_b     = b_q;
  assign dsp_d     = d_q;
  assign dsp_c     = c_q;
  assign rsp_valid = rsp_q;
  assign rsp_p     = dsp_p;

endmodule

// File: tb/tb_dsp_rr_scheduler.sv
// Directed bench for dsp_rr_scheduler with a behavioural 4-cycle DSP.
// DSP model: P = (B + D) * A + C, flushed while rst is high.
module tb_dsp_rr_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [18*N-1:0] req_a = '0;
  logic [18*N-1:0] req_b = '0;
  logic [18*N-1:0] req_d = '0;
  logic [48*N-1:0] req_c = '0;
  logic [17:0]   dsp_a, dsp_b, dsp_d;
  logic [47:0]   dsp_c, dsp_p;
  logic [N-1:0]  rsp_valid;
  logic [47:0]   rsp_p;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cnum  = 0;

  always #5 clk = ~clk;

  dsp_rr_scheduler #(.N_REQ(N), .DSP_LAT(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_d     (req_d),
    .req_c     (req_c),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_d     (dsp_d),
    .dsp_c     (dsp_c),
    .dsp_p     (dsp_p),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  logic [47:0] p0, p1, p2, p3;
  logic [47:0] mac;

  assign mac = ({30'd0, dsp_b} + {30'd0, dsp_d}) * {30'd0, dsp_a}
             + dsp_c;
  assign dsp_p = p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      p0 <= mac;
      p1 <= p0;
      p2 <= p1;
      p3 <= p2;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cnum, got, exp);
    end
  endtask

  // One cycle: drive at negedge, then check comb and registered outputs
  task automatic cyc(input logic [N-1:0] v,
                     input logic         e,
                     input logic         r,
                     input logic [N-1:0] er,
                     input logic [N-1:0] ers,
                     input logic [47:0]  ep);
    @(negedge clk);
    cnum++;
    req_valid = v;
    en        = e;
    rst       = r;
    #1;
    chk("ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(ers));
    if (ers != '0) chk("rsp_p", 64'(rsp_p), 64'(ep));
  endtask

  task automatic set_std();
    for (int i = 0; i < N; i++) begin
      req_a[18*i +: 18] = 18'd1;
      req_b[18*i +: 18] = 18'd0;
      req_d[18*i +: 18] = 18'd1;
      req_c[48*i +: 48] = 48'(i * 100);
    end
  endtask

  initial begin
    set_std();
    req_a[36 +: 18] = 18'd3;
    req_b[36 +: 18] = 18'd4;
    req_d[36 +: 18] = 18'd5;
    req_c[96 +: 48] = 48'd10;

    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("rst_dsp_c", 64'(dsp_c), 64'd0);

    // single request from requester 2: (4+5)*3+10 = 37
    cyc(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 48'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(4'b0000, 1'b1, 1'b0, 4'b0000,
          (k == 5) ? 4'b0100 : 4'b0000, 48'd37);
      chk("single_busy", 64'(busy), (k <= 4) ? 64'd1 : 64'd0);
      if (k == 1) begin
        chk("single_dsp_a", 64'(dsp_a), 64'd3);
        chk("single_dsp_b", 64'(dsp_b), 64'd4);
        chk("single_dsp_d", 64'(dsp_d), 64'd5);
        chk("single_dsp_c", 64'(dsp_c), 64'd10);
      end
      if (k == 2) chk("idle_dsp_a", 64'(dsp_a), 64'd0);
    end

    set_std();
    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 48'd0);

    // all four valid: rotating grants, back-to-back responses
    for (int n = 0; n <= 12; n++) begin
      cyc((n < 8) ? 4'b1111 : 4'b0000, 1'b1, 1'b0,
          (n < 8) ? 4'(1 << (n % 4)) : 4'b0000,
          (n >= 5) ? 4'(1 << ((n + 3) % 4)) : 4'b0000,
          48'(1 + ((n + 3) % 4) * 100));
    end

    // fairness after grant to 3, then en low for three cycles
    cyc(4'b1001, 1'b1, 1'b0, 4'b0001, 4'b0000, 48'd0);
    cyc(4'b1001, 1'b1, 1'b0, 4'b1000, 4'b0000, 48'd0);
    cyc(4'b0110, 1'b1, 1'b0, 4'b0010, 4'b0000, 48'd0);
    cyc(4'b0110, 1'b1, 1'b0, 4'b0100, 4'b0000, 48'd0);
    cyc(4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0001, 48'd1);
    cyc(4'b0110, 1'b0, 1'b0, 4'b0000, 4'b1000, 48'd301);
    cyc(4'b0110, 1'b1, 1'b0, 4'b0010, 4'b0010, 48'd101);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100, 48'd201);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 48'd101);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    // reset with three operations in flight
    cyc(4'b1111, 1'b1, 1'b0, 4'b0100, 4'b0000, 48'd0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b1000, 4'b0000, 48'd0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000, 48'd0);
    chk("inflight_busy", 64'(busy), 64'd1);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000, 48'd0);
    chk("flush_dsp_a", 64'(dsp_a), 64'd0);
    chk("flush_dsp_c", 64'(dsp_c), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    for (int k = 5; k <= 8; k++) begin
      cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    end
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 48'd1);

    // idle gaps: requests in cycles 0 and 2 only
    cyc(4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 48'd101);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    chk("gap_dsp_p", 64'(dsp_p), 64'd0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 48'd101);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 48'd0);
    chk("end_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
